// File: rtl/color_sequence_ctrl_if.sv
// Signal bundle between the game/menu host (master) and the colour playback controller (slave).
interface color_sequence_ctrl_if #(
    parameter int unsigned SEQ_DEPTH = 16
);
    localparam int unsigned IDX_W = $clog2(SEQ_DEPTH);

    logic             continue_btn;
    logic             mode;
    logic             clr;
    logic             wr_en;
    logic [3:0]       wr_color;
    logic             start;
    logic             abort;
    logic [3:0]       color;
    logic             playing;
    logic [IDX_W-1:0] seq_idx;
    logic [IDX_W:0]   seq_len;
    logic             done;
    logic             wr_err;

    modport master (
        output continue_btn, mode, clr, wr_en, wr_color, start, abort,
        input  color, playing, seq_idx, seq_len, done, wr_err
    );

    modport slave (
        input  continue_btn, mode, clr, wr_en, wr_color, start, abort,
        output color, playing, seq_idx, seq_len, done, wr_err
    );
endinterface

// File: rtl/color_sequence_ctrl.sv
// Colour-sequence playback: buffers up to SEQ_DEPTH colour codes and plays them either
// on a fixed dwell/gap timer (AUTO) or advancing on a debounced button press (STEP).
module color_sequence_ctrl #(
    parameter int unsigned DWELL_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES      = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SEQ_DEPTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    color_sequence_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(SEQ_DEPTH);
    localparam int unsigned TMAX  = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned TW    = $clog2(TMAX + 1);
    localparam int unsigned DW    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [TW-1:0]    DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [DW-1:0]    DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W:0]   DEPTH_L    = (IDX_W + 1)'(SEQ_DEPTH);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, WAIT_BTN} state_e;

    logic          sync1_q, sync2_q, deb_q, press_q;
    logic [DW-1:0] deb_cnt_q;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive samples differing from it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            press_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q <= bus.continue_btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_q     <= sync2_q;
                deb_cnt_q <= '0;
                press_q   <= sync2_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
        end
    end

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   len_q, len_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             werr_q, werr_d;
    logic             buf_we;
    logic             legal;
    logic             last_entry;
    logic [3:0]       buf_q [SEQ_DEPTH];

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        idx_d      = idx_q;
        len_d      = len_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        werr_d     = 1'b0;
        buf_we     = 1'b0;
        legal      = (bus.wr_color >= 4'd2) && (bus.wr_color <= 4'd5);
        last_entry = ({1'b0, idx_q} == (len_q - (IDX_W + 1)'(1)));

        if (bus.abort) begin
            state_d = IDLE;
            idx_d   = '0;
            tmr_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                if (len_q != '0) begin
                    state_d = SHOW;
                    mode_d  = bus.mode;
                    idx_d   = '0;
                    tmr_d   = '0;
                end else begin
                    done_d = 1'b1;
                end
            end else if (bus.clr) begin
                len_d = '0;
            end else if (bus.wr_en) begin
                if (legal && (len_q < DEPTH_L)) begin
                    buf_we = 1'b1;
                    len_d  = len_q + (IDX_W + 1)'(1);
                end else begin
                    werr_d = 1'b1;
                end
            end
        end else begin
            werr_d = bus.wr_en;
            case (state_q)
                SHOW: begin
                    if (tmr_q == DWELL_LAST) begin
                        tmr_d   = '0;
                        state_d = mode_q ? WAIT_BTN : GAP;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                WAIT_BTN: begin
                    if (press_q) begin
                        state_d = GAP;
                        tmr_d   = '0;
                    end
                end
                GAP: begin
                    if (tmr_q == GAP_LAST) begin
                        tmr_d = '0;
                        if (last_entry) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = SHOW;
                        end
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            werr_q  <= werr_d;
        end
    end

    // Buffer contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[len_q[IDX_W-1:0]] <= bus.wr_color;
        end
    end

    assign bus.color   = ((state_q == SHOW) || (state_q == WAIT_BTN)) ? buf_q[idx_q] : 4'd0;
    assign bus.playing = (state_q != IDLE);
    assign bus.seq_idx = idx_q;
    assign bus.seq_len = len_q;
    assign bus.done    = done_q;
    assign bus.wr_err  = werr_q;
endmodule
